// File: rtl/door_ctrl_gen2_if.sv
// -----------------------------------------------------------------------------
// door_ctrl_gen2_if
// Signal bundle between the car controller and the door controller.
//
// Car-controller side (master drives, slave receives):
//   enable              tick strobe; door timing advances only on ticks
//   currentFloor        floor the car is at, 1..N_FLOORS
//   currentDirection    STOP=00, UP=10, DOWN=01, UPDOWN=11 (invalid)
//   currentFloorButton  hall requests at the current floor, same encoding
//   internalButton      [k] car call k (1..N_FLOORS), [N_FLOORS+1] CLOSE_B,
//                       [N_FLOORS+2] OPEN_B
//   moving              car is in motion
//   obstruct            door-edge obstruction sensor
// Door-controller side (slave drives, master receives):
//   door_state          CLOSED=00, OPENING=01, OPEN=10, CLOSING=11
//   doorState           door is fully open
//   door_closed         door is fully closed (car motion interlock)
//   motor_open          drive door motor in the open direction
//   motor_close         drive door motor in the close direction
//   nudge               nudge mode active
//   fault               sticky moving-interlock fault
// -----------------------------------------------------------------------------
interface door_ctrl_gen2_if #(
    parameter int N_FLOORS = 7,
    parameter int FLOOR_W  = 3
);
    logic                  enable;
    logic [FLOOR_W-1:0]    currentFloor;
    logic [1:0]            currentDirection;
    logic [1:0]            currentFloorButton;
    logic [N_FLOORS+2:1]   internalButton;
    logic                  moving;
    logic                  obstruct;

    logic [1:0]            door_state;
    logic                  doorState;
    logic                  door_closed;
    logic                  motor_open;
    logic                  motor_close;
    logic                  nudge;
    logic                  fault;

    modport master (
        output enable, currentFloor, currentDirection, currentFloorButton,
               internalButton, moving, obstruct,
        input  door_state, doorState, door_closed, motor_open, motor_close,
               nudge, fault
    );

    modport slave (
        input  enable, currentFloor, currentDirection, currentFloorButton,
               internalButton, moving, obstruct,
        output door_state, doorState, door_closed, motor_open, motor_close,
               nudge, fault
    );
endinterface

// File: rtl/door_ctrl_gen2.sv
// -----------------------------------------------------------------------------
// door_ctrl_gen2
// Single-car door controller. Tracks door travel through four states, reopens
// on obstruction or request while closing, falls back to nudge mode after
// MAX_REOPEN reopens, and latches a fault if the car moves with the door not
// closed. All timing advances on bus.enable ticks; the interlock is checked
// on every clock.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    door_ctrl_gen2_if.slave (car-controller inputs, door outputs)
//
// state   | meaning
// --------+--------------------------------------------------------------
// CLOSED  | door shut; car may move; waits for an open request
// OPENING | motor opening; tcnt counts the stroke down
// OPEN    | door open; dcnt counts dwell down, requests reload it
// CLOSING | motor closing; reopen on obstruct/request unless in nudge
// -----------------------------------------------------------------------------
module door_ctrl_gen2 #(
    parameter int N_FLOORS     = 7,
    parameter int FLOOR_W      = 3,
    parameter int CNT_W        = 8,
    parameter int TRAVEL_TICKS = 2,
    parameter int DWELL_TICKS  = 5,
    parameter int MAX_REOPEN   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    door_ctrl_gen2_if.slave      bus
);

    typedef enum logic [1:0] {
        CLOSED  = 2'b00,
        OPENING = 2'b01,
        OPEN    = 2'b10,
        CLOSING = 2'b11
    } state_t;

    localparam int RW = (MAX_REOPEN < 2) ? 1 : $clog2(MAX_REOPEN + 1);

    localparam logic [CNT_W-1:0] TRAVEL_C = CNT_W'(TRAVEL_TICKS);
    localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL_TICKS);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [RW-1:0]    MAXR_C   = RW'(MAX_REOPEN);

    localparam int CLOSE_IDX = N_FLOORS + 1;
    localparam int OPEN_IDX  = N_FLOORS + 2;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0]    dcnt_q, dcnt_d;
    logic [RW-1:0]       reopen_q, reopen_d;
    logic                nudge_q, nudge_d;
    logic                fault_q, fault_d;

    logic                car_call;
    logic                req_raw;
    logic                req;
    logic                opn;
    logic                close_b;
    logic                held;
    logic                trip;
    logic                freeze;

    // Car call at the current floor; floors outside 1..N_FLOORS never match,
    // so a bad floor code cannot alias onto CLOSE_B/OPEN_B.
    always_comb begin
        car_call = 1'b0;
        for (int k = 1; k <= N_FLOORS; k++) begin
            if (int'(bus.currentFloor) == k) begin
                car_call = bus.internalButton[k];
            end
        end
    end

    // Direction-qualified open request. UPDOWN is treated as invalid and
    // suppresses the car call too, so it can never open the door.
    always_comb begin
        req_raw = 1'b0;
        if (!bus.moving) begin
            case (bus.currentDirection)
                2'b00:   req_raw = |bus.currentFloorButton;
                2'b10:   req_raw = bus.currentFloorButton[1] | car_call;
                2'b01:   req_raw = bus.currentFloorButton[0] | car_call;
                default: req_raw = 1'b0;
            endcase
        end
    end

    assign req     = req_raw & ~nudge_q;
    assign close_b = bus.internalButton[CLOSE_IDX];
    assign opn     = bus.internalButton[OPEN_IDX] & ~bus.moving & ~nudge_q;
    assign held    = nudge_q & bus.obstruct;

    // The interlock trip freezes the FSM on the same edge the fault latches,
    // so no tick can slip through while the car is already moving.
    assign trip    = bus.moving && (state_q != CLOSED);
    assign freeze  = fault_q | trip;
    assign fault_d = fault_q | trip;

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        dcnt_d   = dcnt_q;
        reopen_d = reopen_q;
        nudge_d  = nudge_q;

        if (bus.enable && !freeze) begin
            case (state_q)
                CLOSED: begin
                    if (req || opn) begin
                        state_d = OPENING;
                        tcnt_d  = TRAVEL_C;
                    end
                end

                OPENING: begin
                    if (tcnt_q <= ONE_C) begin
                        state_d = OPEN;
                        tcnt_d  = '0;
                        dcnt_d  = DWELL_C;
                    end else begin
                        tcnt_d = tcnt_q - ONE_C;
                    end
                end

                OPEN: begin
                    if (req || opn) begin
                        dcnt_d = DWELL_C;
                    end else if (dcnt_q == '0) begin
                        state_d = CLOSING;
                        tcnt_d  = TRAVEL_C;
                    end else if (close_b) begin
                        dcnt_d = '0;
                    end else begin
                        dcnt_d = dcnt_q - ONE_C;
                    end
                end

                CLOSING: begin
                    if (!nudge_q && (bus.obstruct || req || opn)) begin
                        state_d = OPENING;
                        tcnt_d  = TRAVEL_C;
                        if (reopen_q != MAXR_C) begin
                            reopen_d = reopen_q + 1'b1;
                        end
                        if (reopen_d == MAXR_C) begin
                            nudge_d = 1'b1;
                        end
                    end else if (held) begin
                        // Nudge: the door waits on the obstruction, stroke paused.
                        tcnt_d = tcnt_q;
                    end else if (tcnt_q <= ONE_C) begin
                        state_d  = CLOSED;
                        tcnt_d   = '0;
                        reopen_d = '0;
                        nudge_d  = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q - ONE_C;
                    end
                end

                default: begin
                    state_d = CLOSED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= CLOSED;
            tcnt_q   <= '0;
            dcnt_q   <= '0;
            reopen_q <= '0;
            nudge_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            dcnt_q   <= dcnt_d;
            reopen_q <= reopen_d;
            nudge_q  <= nudge_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.door_state  = state_q;
    assign bus.doorState   = (state_q == OPEN);
    assign bus.door_closed = (state_q == CLOSED);
    assign bus.motor_open  = (state_q == OPENING) & ~fault_q;
    assign bus.motor_close = (state_q == CLOSING) & ~fault_q & ~held;
    assign bus.nudge       = nudge_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_door_ctrl_gen2.sv
module tb_door_ctrl_gen2;

    localparam int NF = 7;
    localparam int FW = 3;
    localparam int CB = NF + 1;
    localparam int OB = NF + 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    door_ctrl_gen2_if #(.N_FLOORS(NF), .FLOOR_W(FW)) bus ();

    door_ctrl_gen2 #(
        .N_FLOORS(NF), .FLOOR_W(FW), .CNT_W(8),
        .TRAVEL_TICKS(2), .DWELL_TICKS(5), .MAX_REOPEN(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  tests_run    = 0;
    int  tests_failed = 0;

    // Output vector: {door_state, doorState, door_closed, motor_open,
    //                 motor_close, nudge, fault}
    function automatic logic [7:0] model(logic [1:0] st, logic ng, logic ft, logic hd);
        return {st, (st == 2'b10), (st == 2'b00), ((st == 2'b01) & ~ft),
                ((st == 2'b11) & ~ft & ~hd), ng, ft};
    endfunction

    task automatic expect_out(string tag, logic [1:0] st, logic ng, logic ft, logic hd);
        sb_t e;
        e.tag = tag;
        e.exp = model(st, ng, ft, hd);
        sb_q.push_back(e);
    endtask

    task automatic compare_front();
        sb_t        e;
        logic [7:0] obs;
        e   = sb_q.pop_front();
        obs = {bus.door_state, bus.doorState, bus.door_closed, bus.motor_open,
               bus.motor_close, bus.nudge, bus.fault};
        tests_run++;
        assert (obs === e.exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
        end
    endtask

    task automatic step(string tag, logic [1:0] st, logic ng = 1'b0,
                        logic ft = 1'b0, logic hd = 1'b0);
        expect_out(tag, st, ng, ft, hd);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic check_now(string tag, logic [1:0] st, logic ng = 1'b0,
                             logic ft = 1'b0, logic hd = 1'b0);
        expect_out(tag, st, ng, ft, hd);
        compare_front();
    endtask

    // Trigger already applied; runs OPENING(2), OPEN(6) and the first CLOSING tick.
    task automatic cycle_to_closing(string tag, logic ng);
        step({tag, "_opening0"}, 2'b01, ng);
        bus.obstruct           = 1'b0;
        bus.internalButton     = '0;
        bus.currentFloorButton = 2'b00;
        step({tag, "_opening1"}, 2'b01, ng);
        repeat (6) step({tag, "_open"}, 2'b10, ng);
        step({tag, "_closing0"}, 2'b11, ng);
    endtask

    task automatic finish_close(string tag, logic ng);
        step({tag, "_closing1"}, 2'b11, ng);
        step({tag, "_closed"}, 2'b00, 1'b0);
    endtask

    initial begin
        reset                  = 1'b0;
        bus.enable             = 1'b1;
        bus.currentFloor       = 3'd3;
        bus.currentDirection   = 2'b00;
        bus.currentFloorButton = 2'b00;
        bus.internalButton     = '0;
        bus.moving             = 1'b0;
        bus.obstruct           = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", 2'b00);
        reset = 1'b1;

        // Basic hall call at STOP: 2 ticks opening, 6 open, 2 closing.
        bus.currentFloorButton = 2'b10;
        cycle_to_closing("s1", 1'b0);
        finish_close("s1", 1'b0);

        // CLOSE_B at dcnt=4 empties dwell, closes on the following tick.
        bus.internalButton[OB] = 1'b1;
        step("s2_open0", 2'b01);
        bus.internalButton = '0;
        step("s2_open1", 2'b01);
        step("s2_open_d5", 2'b10);
        step("s2_open_d4", 2'b10);
        bus.internalButton[CB] = 1'b1;
        step("s2_closeb_d0", 2'b10);
        bus.internalButton = '0;
        step("s2_closeb_closing", 2'b11);
        step("s2_closing1", 2'b11);
        step("s2_closed", 2'b00);

        // OPEN_B together with CLOSE_B reloads dwell instead of closing.
        bus.internalButton[OB] = 1'b1;
        step("s2b_open0", 2'b01);
        bus.internalButton = '0;
        step("s2b_open1", 2'b01);
        step("s2b_d5", 2'b10);
        step("s2b_d4", 2'b10);
        step("s2b_d3", 2'b10);
        bus.internalButton[OB] = 1'b1;
        bus.internalButton[CB] = 1'b1;
        step("s2b_both_reload", 2'b10);
        bus.internalButton = '0;
        repeat (5) step("s2b_dwell", 2'b10);
        step("s2b_closing0", 2'b11);
        step("s2b_closing1", 2'b11);
        step("s2b_closed", 2'b00);

        // Three reopens (first with CLOSE_B also pressed) lead to nudge.
        bus.internalButton[OB] = 1'b1;
        cycle_to_closing("s3_first", 1'b0);
        bus.obstruct = 1'b1;
        bus.internalButton[CB] = 1'b1;
        cycle_to_closing("s3_reopen1", 1'b0);
        bus.obstruct = 1'b1;
        cycle_to_closing("s3_reopen2", 1'b0);
        bus.obstruct = 1'b1;
        cycle_to_closing("s3_reopen3", 1'b1);
        bus.obstruct = 1'b1;
        repeat (3) step("s3_held", 2'b11, 1'b1, 1'b0, 1'b1);
        bus.obstruct = 1'b0;
        step("s3_release", 2'b11, 1'b1);
        step("s3_closed", 2'b00, 1'b0);

        // Reopen counter cleared at CLOSED: a single reopen must not nudge.
        bus.internalButton[OB] = 1'b1;
        cycle_to_closing("s3b_open", 1'b0);
        bus.obstruct = 1'b1;
        cycle_to_closing("s3b_reopen", 1'b0);
        finish_close("s3b", 1'b0);

        // Direction qualification.
        bus.currentFloor       = 3'd4;
        bus.currentDirection   = 2'b10;
        bus.internalButton[4]  = 1'b1;
        bus.currentFloorButton = 2'b01;
        cycle_to_closing("s4_up_car", 1'b0);
        finish_close("s4_up_car", 1'b0);

        bus.currentFloorButton = 2'b10;
        cycle_to_closing("s4_up_hall", 1'b0);
        finish_close("s4_up_hall", 1'b0);

        bus.currentDirection   = 2'b01;
        bus.currentFloorButton = 2'b10;
        step("s4_dn_nomatch", 2'b00);
        step("s4_dn_nomatch2", 2'b00);
        bus.currentFloorButton = 2'b01;
        cycle_to_closing("s4_dn_hall", 1'b0);
        finish_close("s4_dn_hall", 1'b0);

        bus.currentDirection   = 2'b11;
        bus.currentFloorButton = 2'b11;
        bus.internalButton[4]  = 1'b1;
        step("s4_updown", 2'b00);
        step("s4_updown2", 2'b00);

        bus.currentDirection   = 2'b00;
        bus.currentFloorButton = 2'b00;
        step("s4_stop_car_ignored", 2'b00);
        bus.internalButton     = '0;
        bus.currentFloorButton = 2'b10;
        bus.moving             = 1'b1;
        step("s4_moving_closed", 2'b00);
        step("s4_moving_closed2", 2'b00);
        bus.moving             = 1'b0;
        bus.currentFloorButton = 2'b00;

        // Interlock fault while OPEN, then async reset.
        bus.internalButton[OB] = 1'b1;
        step("s5_open0", 2'b01);
        bus.internalButton = '0;
        step("s5_open1", 2'b01);
        step("s5_d5", 2'b10);
        step("s5_d4", 2'b10);
        bus.moving = 1'b1;
        step("s5_fault", 2'b10, 1'b0, 1'b1);
        bus.moving = 1'b0;
        repeat (8) step("s5_frozen", 2'b10, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        check_now("s5_async_reset", 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Fault while OPENING kills motor_open.
        bus.internalButton[OB] = 1'b1;
        step("s5b_open0", 2'b01);
        bus.internalButton = '0;
        bus.moving = 1'b1;
        step("s5b_fault_opening", 2'b01, 1'b0, 1'b1);
        bus.moving = 1'b0;
        step("s5b_frozen", 2'b01, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        check_now("s5b_async_reset", 2'b00);
        #2;
        reset = 1'b1;

        // enable low for 20 clocks mid-OPENING: travel resumes where it stopped.
        @(posedge clk);
        #1;
        bus.internalButton[OB] = 1'b1;
        step("s6_open0", 2'b01);
        bus.internalButton = '0;
        bus.enable = 1'b0;
        repeat (20) step("s6_hold", 2'b01);
        bus.enable = 1'b1;
        step("s6_resume", 2'b01);
        step("s6_open_reached", 2'b10);
        repeat (5) step("s6_dwell", 2'b10);
        step("s6_closing0", 2'b11);
        step("s6_closing1", 2'b11);
        step("s6_closed", 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
